// File: rtl/fp16_adder_pkg.sv
// rtl/fp16_adder_pkg.sv - shared states, constants and helpers for the half-precision adder
package fp16_adder_pkg;

    localparam int EXP_BITS  = 5;
    localparam int MAN_BITS  = 10;
    localparam int WORD_BITS = 1 + EXP_BITS + MAN_BITS;   // 16
    localparam int SIG_BITS  = MAN_BITS + 1;              // hidden + stored = 11
    localparam int WORK_BITS = SIG_BITS + 3;              // + guard/round/sticky = 14
    localparam int EXPW      = 8;                         // signed working exponent

    localparam logic signed [EXPW-1:0] EXP_BIAS  = 8'sd15;
    localparam logic signed [EXPW-1:0] EXP_MIN   = -8'sd14;
    localparam logic signed [EXPW-1:0] EXP_MAX   = 8'sd15;
    // Beyond this exponent gap every mantissa bit lands in sticky.
    localparam logic signed [EXPW-1:0] ALIGN_MAX = 8'sd13;

    localparam logic [WORD_BITS-1:0] QNAN    = 16'h7E00;
    localparam logic [WORD_BITS-1:0] POS_INF = 16'h7C00;

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0,
        ADD_1, NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_t;

    // One-bit right shift of a working mantissa; the dropped bit folds into sticky.
    function automatic logic [WORK_BITS-1:0] shr_sticky(input logic [WORK_BITS-1:0] m);
        return {1'b0, m[WORK_BITS-1:2], m[1] | m[0]};
    endfunction

endpackage

// File: rtl/fp16_unpack.sv
// rtl/fp16_unpack.sv - combinational split of a half-precision word into fields and class flags
// Ports:
//   i_x        16-bit IEEE-754 half-precision word
//   o_sign     sign bit
//   o_exp      signed unbiased exponent (subnormal/zero report EXP_MIN)
//   o_man      11-bit significand including hidden bit
//   o_is_zero  +/-0
//   o_is_inf   +/-infinity
//   o_is_nan   any NaN
//   o_is_sub   nonzero subnormal
module fp16_unpack
    import fp16_adder_pkg::*;
(
    input  logic [WORD_BITS-1:0]   i_x,
    output logic                   o_sign,
    output logic signed [EXPW-1:0] o_exp,
    output logic [SIG_BITS-1:0]    o_man,
    output logic                   o_is_zero,
    output logic                   o_is_inf,
    output logic                   o_is_nan,
    output logic                   o_is_sub
);

    logic [EXP_BITS-1:0] w_exp_f;
    logic [MAN_BITS-1:0] w_man_f;
    logic                w_exp_zero;
    logic                w_exp_ones;
    logic                w_man_zero;

    assign w_exp_f    = i_x[WORD_BITS-2 -: EXP_BITS];
    assign w_man_f    = i_x[MAN_BITS-1:0];
    assign w_exp_zero = (w_exp_f == '0);
    assign w_exp_ones = &w_exp_f;
    assign w_man_zero = (w_man_f == '0);

    assign o_sign    = i_x[WORD_BITS-1];
    assign o_exp     = w_exp_zero ? EXP_MIN
                                  : $signed({{(EXPW-EXP_BITS){1'b0}}, w_exp_f}) - EXP_BIAS;
    assign o_man     = {~w_exp_zero, w_man_f};
    assign o_is_zero = w_exp_zero & w_man_zero;
    assign o_is_sub  = w_exp_zero & ~w_man_zero;
    assign o_is_inf  = w_exp_ones & w_man_zero;
    assign o_is_nan  = w_exp_ones & ~w_man_zero;

endmodule

// File: rtl/fp16_adder.sv
// rtl/fp16_adder.sv - multi-cycle IEEE-754 half-precision adder, round-to-nearest-even
// Optional feature macro: FP16_ADDER_SUBNORMAL_EN (gradual underflow; otherwise subnormals flush to zero)
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   input_a/_stb/_ack             operand A channel
//   input_b/_stb/_ack             operand B channel
//   output_z/_stb/_ack            sum channel
module fp16_adder
    import fp16_adder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_BITS-1:0] input_a,
    input  logic                 input_a_stb,
    output logic                 input_a_ack,
    input  logic [WORD_BITS-1:0] input_b,
    input  logic                 input_b_stb,
    output logic                 input_b_ack,
    output logic [WORD_BITS-1:0] output_z,
    output logic                 output_z_stb,
    input  logic                 output_z_ack
);

    state_t r_state, w_next_state;

    logic [WORD_BITS-1:0] r_a, r_b, r_z;
    logic                 r_a_ack, r_b_ack, r_z_stb;

    logic                 r_a_s, r_b_s, r_z_s;
    logic signed [EXPW-1:0] r_a_e, r_b_e, r_z_e;
    logic [WORK_BITS-1:0] r_a_m, r_b_m;
    logic [WORK_BITS:0]   r_z_m;                 // extra top bit catches the add carry
    logic                 r_a_zero, r_a_inf, r_a_nan;
    logic                 r_b_zero, r_b_inf, r_b_nan;

    logic                 w_a_sign, w_b_sign;
    logic signed [EXPW-1:0] w_a_exp, w_b_exp;
    logic [SIG_BITS-1:0]  w_a_man, w_b_man;
    logic                 w_a_zero, w_a_inf, w_a_nan, w_a_sub;
    logic                 w_b_zero, w_b_inf, w_b_nan, w_b_sub;

    fp16_unpack u_unpack_a (
        .i_x(r_a), .o_sign(w_a_sign), .o_exp(w_a_exp), .o_man(w_a_man),
        .o_is_zero(w_a_zero), .o_is_inf(w_a_inf), .o_is_nan(w_a_nan), .o_is_sub(w_a_sub)
    );

    fp16_unpack u_unpack_b (
        .i_x(r_b), .o_sign(w_b_sign), .o_exp(w_b_exp), .o_man(w_b_man),
        .o_is_zero(w_b_zero), .o_is_inf(w_b_inf), .o_is_nan(w_b_nan), .o_is_sub(w_b_sub)
    );

    logic                   w_a_is_zero, w_b_is_zero;
`ifdef FP16_ADDER_SUBNORMAL_EN
    assign w_a_is_zero = w_a_zero;
    assign w_b_is_zero = w_b_zero;
`else
    // Without gradual underflow a subnormal operand behaves as a signed zero.
    assign w_a_is_zero = w_a_zero | w_a_sub;
    assign w_b_is_zero = w_b_zero | w_b_sub;
`endif

    logic                   w_special;
    logic [WORD_BITS-1:0]   w_special_z;
    logic signed [EXPW-1:0] w_exp_diff;
    logic [WORK_BITS:0]     w_sum;
    logic                   w_sum_s;
    logic                   w_round_up;
    logic [SIG_BITS:0]      w_rnd;
    logic [EXP_BITS-1:0]    w_exp_field;
    logic [WORD_BITS-1:0]   w_pack;

    always_comb begin
        w_special   = 1'b1;
        w_special_z = '0;
        if (r_a_nan || r_b_nan || (r_a_inf && r_b_inf && (r_a_s != r_b_s)))
            w_special_z = QNAN;
        else if (r_a_inf)
            w_special_z = r_a;
        else if (r_b_inf)
            w_special_z = r_b;
        else if (r_a_zero && r_b_zero)
            w_special_z = {r_a_s & r_b_s, {(WORD_BITS-1){1'b0}}};
        else if (r_a_zero)
            w_special_z = r_b;
        else if (r_b_zero)
            w_special_z = r_a;
        else
            w_special = 1'b0;

        w_exp_diff = (r_a_e > r_b_e) ? (r_a_e - r_b_e) : (r_b_e - r_a_e);

        // Exponents are equal here, so the larger mantissa is the larger magnitude.
        w_sum   = '0;
        w_sum_s = r_a_s;
        if (r_a_s == r_b_s) begin
            w_sum   = {1'b0, r_a_m} + {1'b0, r_b_m};
            w_sum_s = r_a_s;
        end else if (r_a_m >= r_b_m) begin
            w_sum   = {1'b0, r_a_m} - {1'b0, r_b_m};
            w_sum_s = r_a_s;
        end else begin
            w_sum   = {1'b0, r_b_m} - {1'b0, r_a_m};
            w_sum_s = r_b_s;
        end

        // Bits [2:0] of r_z_m are guard, round, sticky; bit 3 is the result lsb.
        w_round_up  = r_z_m[2] & (r_z_m[1] | r_z_m[0] | r_z_m[3]);
        w_rnd       = {1'b0, r_z_m[WORK_BITS-1:3]} + 1'b1;
        w_exp_field = r_z_e[EXP_BITS-1:0] + EXP_BIAS[EXP_BITS-1:0];

        if (r_z_e > EXP_MAX)
            w_pack = {r_z_s, POS_INF[WORD_BITS-2:0]};
        else if (r_z_e == EXP_MIN && !r_z_m[WORK_BITS-1])
            w_pack = {r_z_s, {EXP_BITS{1'b0}}, r_z_m[WORK_BITS-2:3]};
        else
            w_pack = {r_z_s, w_exp_field, r_z_m[WORK_BITS-2:3]};
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            GET_A:   if (r_a_ack && input_a_stb) w_next_state = GET_B;
            GET_B:   if (r_b_ack && input_b_stb) w_next_state = UNPACK;
            UNPACK:  w_next_state = SPECIAL;
            SPECIAL: begin
                if (w_special)            w_next_state = PUT_Z;
                else if (r_a_e == r_b_e)  w_next_state = ADD_0;
                else                      w_next_state = ALIGN;
            end
            ALIGN:   if (r_a_e == r_b_e) w_next_state = ADD_0;
            ADD_0:   w_next_state = (w_sum == '0) ? PUT_Z : ADD_1;
            ADD_1:   w_next_state = NORM_1;
            NORM_1: begin
                if (r_z_m[WORK_BITS-1] || r_z_e <= EXP_MIN) begin
`ifdef FP16_ADDER_SUBNORMAL_EN
                    w_next_state = (r_z_e < EXP_MIN) ? NORM_2 : ROUND;
`else
                    w_next_state = ROUND;
`endif
                end
            end
`ifdef FP16_ADDER_SUBNORMAL_EN
            NORM_2:  if (r_z_e >= EXP_MIN) w_next_state = ROUND;
`endif
            ROUND:   w_next_state = PACK;
            PACK:    w_next_state = PUT_Z;
            PUT_Z:   if (r_z_stb && output_z_ack) w_next_state = GET_A;
            default: w_next_state = GET_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= GET_A;
        else      r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0;  r_b <= '0;  r_z <= '0;
            r_a_ack <= 1'b0; r_b_ack <= 1'b0; r_z_stb <= 1'b0;
            r_a_s <= 1'b0; r_b_s <= 1'b0; r_z_s <= 1'b0;
            r_a_e <= '0; r_b_e <= '0; r_z_e <= '0;
            r_a_m <= '0; r_b_m <= '0; r_z_m <= '0;
            r_a_zero <= 1'b0; r_a_inf <= 1'b0; r_a_nan <= 1'b0;
            r_b_zero <= 1'b0; r_b_inf <= 1'b0; r_b_nan <= 1'b0;
        end else begin
            case (r_state)
                GET_A: begin
                    r_a_ack <= 1'b1;
                    if (r_a_ack && input_a_stb) begin
                        r_a     <= input_a;
                        r_a_ack <= 1'b0;
                    end
                end
                GET_B: begin
                    r_b_ack <= 1'b1;
                    if (r_b_ack && input_b_stb) begin
                        r_b     <= input_b;
                        r_b_ack <= 1'b0;
                    end
                end
                UNPACK: begin
                    r_a_s <= w_a_sign; r_a_e <= w_a_exp; r_a_m <= {w_a_man, 3'b000};
                    r_b_s <= w_b_sign; r_b_e <= w_b_exp; r_b_m <= {w_b_man, 3'b000};
                    r_a_zero <= w_a_is_zero; r_a_inf <= w_a_inf; r_a_nan <= w_a_nan;
                    r_b_zero <= w_b_is_zero; r_b_inf <= w_b_inf; r_b_nan <= w_b_nan;
                end
                SPECIAL: begin
                    if (w_special) begin
                        r_z     <= w_special_z;
                        r_z_stb <= 1'b1;
                    end
                end
                ALIGN: begin
                    if (r_a_e > r_b_e) begin
                        if (w_exp_diff > ALIGN_MAX) begin
                            r_b_m <= {{(WORK_BITS-1){1'b0}}, |r_b_m};
                            r_b_e <= r_a_e;
                        end else begin
                            r_b_m <= shr_sticky(r_b_m);
                            r_b_e <= r_b_e + 8'sd1;
                        end
                    end else if (r_b_e > r_a_e) begin
                        if (w_exp_diff > ALIGN_MAX) begin
                            r_a_m <= {{(WORK_BITS-1){1'b0}}, |r_a_m};
                            r_a_e <= r_b_e;
                        end else begin
                            r_a_m <= shr_sticky(r_a_m);
                            r_a_e <= r_a_e + 8'sd1;
                        end
                    end
                end
                ADD_0: begin
                    if (w_sum == '0) begin
                        // Exact cancellation always yields +0.
                        r_z     <= '0;
                        r_z_stb <= 1'b1;
                    end else begin
                        r_z_m <= w_sum;
                        r_z_s <= w_sum_s;
                        r_z_e <= r_a_e;
                    end
                end
                ADD_1: begin
                    if (r_z_m[WORK_BITS]) begin
                        r_z_m <= {1'b0, r_z_m[WORK_BITS:2], r_z_m[1] | r_z_m[0]};
                        r_z_e <= r_z_e + 8'sd1;
                    end
                end
                NORM_1: begin
                    if (!r_z_m[WORK_BITS-1] && r_z_e > EXP_MIN) begin
                        r_z_m <= {r_z_m[WORK_BITS-1:0], 1'b0};
                        r_z_e <= r_z_e - 8'sd1;
                    end
`ifndef FP16_ADDER_SUBNORMAL_EN
                    else if (!r_z_m[WORK_BITS-1] || r_z_e < EXP_MIN) begin
                        // A result below the normal range flushes to signed zero.
                        r_z_m <= '0;
                        r_z_e <= EXP_MIN;
                    end
`endif
                end
`ifdef FP16_ADDER_SUBNORMAL_EN
                NORM_2: begin
                    if (r_z_e < EXP_MIN) begin
                        r_z_m <= {1'b0, r_z_m[WORK_BITS:2], r_z_m[1] | r_z_m[0]};
                        r_z_e <= r_z_e + 8'sd1;
                    end
                end
`endif
                ROUND: begin
                    if (w_round_up) begin
                        if (w_rnd[SIG_BITS]) begin
                            r_z_m <= {2'b01, {(WORK_BITS-1){1'b0}}};
                            r_z_e <= r_z_e + 8'sd1;
                        end else begin
                            r_z_m <= {1'b0, w_rnd[SIG_BITS-1:0], 3'b000};
                        end
                    end
                end
                PACK: begin
                    r_z     <= w_pack;
                    r_z_stb <= 1'b1;
                end
                PUT_Z: begin
                    if (r_z_stb && output_z_ack) r_z_stb <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign input_a_ack  = r_a_ack;
    assign input_b_ack  = r_b_ack;
    assign output_z     = r_z;
    assign output_z_stb = r_z_stb;

endmodule

// File: tb/tb_fp16_adder.sv
// tb/tb_fp16_adder.sv - self-checking bench for fp16_adder with an exact-arithmetic reference model
module tb_fp16_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] input_a, input_b, output_z;
    logic        input_a_stb, input_a_ack;
    logic        input_b_stb, input_b_ack;
    logic        output_z_stb, output_z_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp16_adder dut (
        .clk(clk), .rst(rst),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value of a finite half in units of 2^-24 (exact integer).
    function automatic longint scaled(input logic [15:0] x);
        longint mag;
        if (x[14:10] == 5'd0) mag = longint'(x[9:0]);
        else                  mag = longint'({1'b1, x[9:0]}) << (x[14:10] - 1);
        return x[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
        longint s, n, rem, half, mant;
        int     p, shift, ef;
        logic [15:0] r;
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 0);
`ifdef FP16_ADDER_SUBNORMAL_EN
        a_zero = (a[14:0] == 0);
        b_zero = (b[14:0] == 0);
`else
        a_zero = (a[14:10] == 0);
        b_zero = (b[14:10] == 0);
`endif
        if (a_nan || b_nan || (a_inf && b_inf && a[15] != b[15])) return 16'h7E00;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a_zero && b_zero) return {a[15] & b[15], 15'd0};
        if (a_zero) return b;
        if (b_zero) return a;
        s = scaled(a) + scaled(b);
        if (s == 0) return 16'h0000;
        sgn = (s < 0);
        n   = sgn ? -s : s;
        if (n < 1024) begin
`ifdef FP16_ADDER_SUBNORMAL_EN
            r = {sgn, 5'd0, 10'(n)};
`else
            r = {sgn, 15'd0};
`endif
            return r;
        end
        p = 10;
        while ((n >> (p + 1)) != 0) p++;
        shift = p - 10;
        mant  = n >> shift;
        rem   = n - (mant << shift);
        if (shift > 0) begin
            half = longint'(1) << (shift - 1);
            if (rem > half || (rem == half && mant[0])) mant++;
        end
        ef = shift + 1;
        if (mant == 2048) begin mant = 1024; ef++; end
        if (ef >= 31) return {sgn, 15'h7C00};
        r = {sgn, 5'(ef), 10'(mant)};
        return r;
    endfunction

    task automatic send_a(input logic [15:0] v);
        int n = 0;
        input_a = v; input_a_stb = 1'b1;
        while (input_a_ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("a_ack_timeout", {15'd0, input_a_ack}, 16'd1);
        @(posedge clk); #1;
        input_a_stb = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] v);
        int n = 0;
        input_b = v; input_b_stb = 1'b1;
        while (input_b_ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("b_ack_timeout", {15'd0, input_b_ack}, 16'd1);
        @(posedge clk); #1;
        input_b_stb = 1'b0;
    endtask

    task automatic recv(output logic [15:0] z);
        int n = 0;
        while (output_z_stb !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("z_stb_timeout", {15'd0, output_z_stb}, 16'd1);
        z = output_z;
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output logic [15:0] z);
        send_a(a);
        send_b(b);
        recv(z);
    endtask

    logic [15:0] dir_a [10] = '{16'h3C00, 16'h8000, 16'h7C00, 16'h7C00, 16'h7E01,
                                16'h7BFF, 16'h3C00, 16'h3C01, 16'h3C00, 16'h4000};
    logic [15:0] dir_b [10] = '{16'hBC00, 16'h8000, 16'hFC00, 16'h3C00, 16'h0000,
                                16'h7BFF, 16'h1000, 16'h1000, 16'h0000, 16'hC400};
    logic [15:0] dir_z [10] = '{16'h0000, 16'h8000, 16'h7E00, 16'h7C00, 16'h7E00,
                                16'h7C00, 16'h3C00, 16'h3C02, 16'h3C00, 16'hC000};

    initial begin
        logic [15:0] z, a, b, exp5, held;
        int lat;

        rst = 1'b0;
        input_a = '0; input_b = '0;
        input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
        #12;
        check("reset_a_ack", {15'd0, input_a_ack}, 16'd0);
        check("reset_b_ack", {15'd0, input_b_ack}, 16'd0);
        check("reset_z_stb", {15'd0, output_z_stb}, 16'd0);
        check("reset_z", output_z, 16'h0000);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("post_reset_a_ack", {15'd0, input_a_ack}, 16'd1);

        // 1.0 + 1.0 with latency from B transfer to output_z_stb
        send_a(16'h3C00);
        send_b(16'h3C00);
        lat = 0;
        while (output_z_stb !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        check("latency_equal_exp", 16'(lat), 16'd7);
        recv(z);
        check("one_plus_one", z, 16'h4000);

        for (int i = 0; i < 10; i++) begin
            run_op(dir_a[i], dir_b[i], z);
            check($sformatf("directed_%0d_%h_%h", i, dir_a[i], dir_b[i]), z, dir_z[i]);
        end

`ifdef FP16_ADDER_SUBNORMAL_EN
        exp5 = 16'h0002;
`else
        exp5 = 16'h0000;
`endif
        run_op(16'h0001, 16'h0001, z);
        check("subnormal_sum", z, exp5);

        // Output held while the consumer stalls
        send_a(16'h4000);
        send_b(16'h3C00);
        for (int n = 0; n < 200 && output_z_stb !== 1'b1; n++) @(negedge clk);
        held = output_z;
        check("stall_value", held, 16'h4200);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("stall_stb_%0d", i), {15'd0, output_z_stb}, 16'd1);
            check($sformatf("stall_z_%0d", i), output_z, held);
        end
        recv(z);

        // Reset in the middle of a long alignment
        send_a(16'h3C00);
        send_b(16'h1000);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("align_rst_a_ack", {15'd0, input_a_ack}, 16'd0);
        check("align_rst_b_ack", {15'd0, input_b_ack}, 16'd0);
        check("align_rst_z_stb", {15'd0, output_z_stb}, 16'd0);
        check("align_rst_z", output_z, 16'h0000);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("align_rst_release_a_ack", {15'd0, input_a_ack}, 16'd1);
        check("align_rst_release_b_ack", {15'd0, input_b_ack}, 16'd0);

        // A and B presented together: A accepted first
        input_a = 16'h3C01; input_a_stb = 1'b1;
        input_b = 16'h1000; input_b_stb = 1'b1;
        #1;
        check("both_a_ack_first", {15'd0, input_a_ack}, 16'd1);
        check("both_b_ack_waits", {15'd0, input_b_ack}, 16'd0);
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        check("both_a_ack_drop", {15'd0, input_a_ack}, 16'd0);
        check("both_b_ack_still_low", {15'd0, input_b_ack}, 16'd0);
        send_b(16'h1000);
        recv(z);
        check("both_result", z, 16'h3C02);

        // Randomized operands against the exact model
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 2))
                0: b = 16'($urandom);
                1: begin b = a ^ 16'h8000; b[3:0] = 4'($urandom); end
                default: begin b = 16'($urandom); b[14:10] = a[14:10] ^ 5'($urandom_range(0, 3)); end
            endcase
            run_op(a, b, z);
            check($sformatf("random_%0d_%h_%h", i, a, b), z, ref_add(a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
